// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory port, decode handshake, redirect input.
// Latency: none (wires only).
// Backpressure: out_ready from decode throttles out_valid/out_instr/out_pc.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    // Instruction memory (combinational read)
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;

    // Decode handshake
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    // Branch/jump redirect
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;

    // Sequencer side
    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redir_valid,
        input  redir_pc
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redir_valid,
        output redir_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, reads imem, buffers words in a small FIFO for decode.
// Latency: start/redirect sampled at an edge -> PC updated at that edge -> word fetched and valid after the next edge.
// Backpressure: fetch stalls (PC holds) while the FIFO is full and decode does not pop; head holds while !out_ready.
module fetch_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0,
    parameter int PROG_LEN = 10,
    parameter int DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    fetch_sequencer_if.master bus,
    output logic              done,
    output logic              err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(PROG_LEN - 1);
    // One extra bit so PROG_LEN == 2^ADDR_W still compares correctly
    localparam logic [ADDR_W:0]   PROG_LEN_X = (ADDR_W + 1)'(PROG_LEN);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_instr_q [DEPTH];
    logic [DATA_W-1:0]  mem_instr_d [DEPTH];
    logic [ADDR_W-1:0]  mem_pc_q    [DEPTH];
    logic [ADDR_W-1:0]  mem_pc_d    [DEPTH];
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               redir_acc;
    logic               redir_ok;
    logic               pop;
    logic               fetch;

    // Per-cycle event decode; a taken redirect overrides both pop and fetch
    always_comb begin
        redir_acc = bus.redir_valid && ((state_q == S_FETCH) || (state_q == S_DRAIN));
        redir_ok  = ({1'b0, bus.redir_pc} < PROG_LEN_X);
        pop       = out_valid_q && bus.out_ready && !redir_acc;
        fetch     = (state_q == S_FETCH) && !redir_acc && ((cnt_q != DEPTH_C) || pop);
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_instr_d = mem_instr_q;
        mem_pc_d    = mem_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;

        if (redir_acc) begin
            // Flush: the head decode saw this cycle is dropped, not consumed
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (fetch) begin
                mem_instr_d[wr_ptr_q] = bus.imem_data;
                mem_pc_d[wr_ptr_q]    = pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(fetch) - CNT_W'(pop);
        end
    end

    // Sequencer FSM: next state, PC and sticky error
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_ADDR;
                end
            end
            S_FETCH: begin
                if (redir_acc) begin
                    if (redir_ok) begin
                        pc_d    = bus.redir_pc;
                        state_d = S_FETCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (fetch) begin
                    pc_d = pc_q + ADDR_W'(1);
                    // Last program word is now in the FIFO; stop fetching
                    if (pc_q == LAST_PC) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (redir_acc) begin
                    if (redir_ok) begin
                        pc_d    = bus.redir_pc;
                        state_d = S_FETCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (cnt_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_ADDR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered status outputs follow next-state values so they align with the state
    always_comb begin
        out_valid_d = (cnt_d != '0);
        done_d      = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_ADDR;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_instr_q <= '{default: '0};
            mem_pc_q    <= '{default: '0};
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_instr_q <= mem_instr_d;
            mem_pc_q    <= mem_pc_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Output drive: imem address is the PC, decode sees the FIFO head
    always_comb begin
        bus.imem_addr = pc_q;
        bus.out_valid = out_valid_q;
        bus.out_instr = mem_instr_q[rd_ptr_q];
        bus.out_pc    = mem_pc_q[rd_ptr_q];
        done          = done_q;
        err           = err_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: ROM model on imem, scoreboard of expected {pc, instr} per accepted word.
// Latency: expectations are pushed when start/redirect is driven and popped on each decode handshake.
// Backpressure: out_ready is driven per test to exercise stalls.
module tb_fetch_sequencer;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int PROG_LEN = 10;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic done;
    logic err;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(0),
        .PROG_LEN(PROG_LEN),
        .DEPTH   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .bus  (bus),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 10'd0, a};
    endfunction

    assign bus.imem_data = rom_word(bus.imem_addr);

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   pop_cnt;
    int   first_pop_cyc;
    int   last_pop_cyc;
    exp_t exp_q[$];
    exp_t e_mon;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_prog(input int first);
        exp_t e;
        for (int a = first; a < PROG_LEN; a++) begin
            e.pc    = ADDR_W'(a);
            e.instr = rom_word(ADDR_W'(a));
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic wait_head(input logic [ADDR_W-1:0] pc, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid && bus.out_pc == pc) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic clear_stats();
        pop_cnt       = 0;
        first_pop_cyc = 0;
        last_pop_cyc  = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: a handshake not overridden by a redirect consumes one expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.redir_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 1);
            end else begin
                e_mon = exp_q.pop_front();
                chk("sb_pc", 32'(bus.out_pc), 32'(e_mon.pc));
                chk("sb_instr", bus.out_instr, e_mon.instr);
            end
            pop_cnt++;
            if (pop_cnt == 1) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
    end

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        clear_stats();
        repeat (3) tick();

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_pc", 32'(bus.out_pc), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 0);
        rst_n = 1'b1;
        tick();

        // 1: straight run with decode always ready
        bus.out_ready = 1'b1;
        push_prog(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_valid_after_start_edge", 32'(bus.out_valid), 0);
        chk("t1_imem_addr_reset_pc", 32'(bus.imem_addr), 0);
        tick();
        chk("t1_first_valid", 32'(bus.out_valid), 1);
        chk("t1_first_pc", 32'(bus.out_pc), 0);
        wait_done("t1_done_timeout");
        chk("t1_done_lat", 32'(cyc - last_pop_cyc), 1);
        chk("t1_pops", 32'(pop_cnt), 10);
        chk("t1_burst_span", 32'(last_pop_cyc - first_pop_cyc), 9);
        chk("t1_sb_empty", 32'(exp_q.size()), 0);
        repeat (3) tick();
        chk("t1_done_sticky", 32'(done), 1);
        chk("t1_valid_idle", 32'(bus.out_valid), 0);

        // 2: decode stalls for 5 cycles after the first valid word
        clear_stats();
        bus.out_ready = 1'b0;
        push_prog(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_restart_clears_done", 32'(done), 0);
        tick();
        chk("t2_first_valid", 32'(bus.out_valid), 1);
        repeat (4) tick();
        chk("t2_stall_addr", 32'(bus.imem_addr), 2);
        chk("t2_stall_head_pc", 32'(bus.out_pc), 0);
        chk("t2_stall_head_instr", bus.out_instr, rom_word(6'd0));
        chk("t2_stall_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        wait_done("t2_done_timeout");
        chk("t2_pops", 32'(pop_cnt), 10);
        chk("t2_sb_empty", 32'(exp_q.size()), 0);

        // 3: redirect to 7 while pc 3 is the head being offered
        clear_stats();
        push_prog(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_head(6'd3, "t3_head3_timeout");
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 6'd7;
        exp_q.delete();
        push_prog(7);
        tick();
        bus.redir_valid = 1'b0;
        chk("t3_flush_valid", 32'(bus.out_valid), 0);
        chk("t3_redir_addr", 32'(bus.imem_addr), 7);
        tick();
        chk("t3_new_valid", 32'(bus.out_valid), 1);
        chk("t3_new_pc", 32'(bus.out_pc), 7);
        wait_done("t3_done_timeout");
        chk("t3_pops", 32'(pop_cnt), 6);
        chk("t3_sb_empty", 32'(exp_q.size()), 0);
        chk("t3_err", 32'(err), 0);

        // 4: out-of-range redirect during FETCH, then restart keeps err
        clear_stats();
        push_prog(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_head(6'd2, "t4_head2_timeout");
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 6'd12;
        exp_q.delete();
        tick();
        bus.redir_valid = 1'b0;
        chk("t4_err", 32'(err), 1);
        chk("t4_done", 32'(done), 1);
        chk("t4_valid", 32'(bus.out_valid), 0);
        clear_stats();
        push_prog(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart_addr", 32'(bus.imem_addr), 0);
        wait_done("t4_done_timeout");
        chk("t4_pops", 32'(pop_cnt), 10);
        chk("t4_err_sticky", 32'(err), 1);

        // 5: asynchronous reset mid-stream with a full FIFO
        clear_stats();
        push_prog(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_head(6'd3, "t5_head3_timeout");
        bus.out_ready = 1'b0;
        tick();
        chk("t5_pre_addr", 32'(bus.imem_addr), 5);
        chk("t5_pre_valid", 32'(bus.out_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_arst_valid", 32'(bus.out_valid), 0);
        chk("t5_arst_addr", 32'(bus.imem_addr), 0);
        chk("t5_arst_pc", 32'(bus.out_pc), 0);
        chk("t5_arst_instr", bus.out_instr, 0);
        chk("t5_arst_done", 32'(done), 0);
        chk("t5_arst_err", 32'(err), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
        bus.out_ready = 1'b1;
        push_prog(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5_done_timeout");
        chk("t5_pops", 32'(pop_cnt), 10);
        chk("t5_sb_empty", 32'(exp_q.size()), 0);

        // 6: redirect to the last word on a full-FIFO pop; start during FETCH ignored
        clear_stats();
        bus.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("t6_full_addr", 32'(bus.imem_addr), 2);
        bus.out_ready   = 1'b1;
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 6'd9;
        start           = 1'b1;
        push_prog(9);
        tick();
        bus.redir_valid = 1'b0;
        chk("t6_flush_valid", 32'(bus.out_valid), 0);
        tick();
        start = 1'b0;
        chk("t6_head_pc", 32'(bus.out_pc), 9);
        chk("t6_head_valid", 32'(bus.out_valid), 1);
        wait_done("t6_done_timeout");
        repeat (3) tick();
        chk("t6_pops", 32'(pop_cnt), 1);
        chk("t6_sb_empty", 32'(exp_q.size()), 0);
        chk("t6_done_hold", 32'(done), 1);
        chk("t6_valid_after", 32'(bus.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the single-cycle MIPS datapath. It owns the program counter and drives the address of the combinational instruction memory (6-bit word address, 32-bit word). It buffers fetched words in a 2-entry FIFO and hands them to decode over a valid/ready handshake. It also handles branch/jump redirects, flushes, and end-of-program detection.

Parameters:
ADDR_W, 6, instruction word-address width
DATA_W, 32, instruction width
RESET_PC, 0, first address fetched after start
PROG_LEN, 10, number of valid words; the last legal address is PROG_LEN-1
DEPTH, 2, output FIFO entries (power of 2, at least 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins fetching from RESET_PC
imem_addr  out  ADDR_W  address to instruction memory; equals the PC register
imem_data  in  DATA_W  instruction word, combinational from imem_addr in the same cycle
out_valid  out  1  FIFO head is valid
out_ready  in  1  decode accepts the head
out_instr  out  DATA_W  head instruction
out_pc  out  ADDR_W  address of the head instruction
redir_valid  in  1  branch/jump taken
redir_pc  in  ADDR_W  redirect target
done  out  1  program drained and fetching stopped
err  out  1  sticky flag: redirect target is out of range

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, pc=RESET_PC, FIFO count=0.
  - out_valid=0, out_instr=0, out_pc=0, done=0, err=0.
  - imem_addr=RESET_PC.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start -> FETCH, pc=RESET_PC.
  - Otherwise stay; no fetch occurs.
- Pop: out_valid && out_ready at a clock edge removes the head.
- Fetch (FETCH state only): occurs at an edge when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
  - Writes {pc, imem_data} to the FIFO tail.
  - Sets pc=pc+1, wrapping modulo 2^ADDR_W.
- Count update on simultaneous pop and fetch: count is unchanged.
- A fetch of pc==PROG_LEN-1 moves the state to DRAIN. No further fetches occur.
- DRAIN: when count reaches 0 (including a final pop in the same cycle), go to DONE.
- DONE:
  - done=1 and stays high.
  - start -> FETCH, pc=RESET_PC, done cleared. err is not cleared.
- Redirect, accepted in FETCH or DRAIN (ignored in IDLE and DONE), has priority over fetch and pop in the same cycle:
  - FIFO flushed (count=0); any pop that cycle is discarded, and decode must not consume it.
  - If redir_pc<PROG_LEN: pc=redir_pc, state=FETCH.
  - Else: err=1 (sticky), state=DONE, pc unchanged.
- Output timing:
  - out_valid is registered: it is high iff count>0.
  - out_instr/out_pc reflect the FIFO head and hold stable while out_valid && !out_ready.
- Latency:
  - start at edge t -> imem_addr=RESET_PC during cycle t+1 -> out_valid=1 after edge t+2.
  - redirect at edge r -> first new word valid after edge r+2.
- Throughput: one instruction per cycle while out_ready is held high.
- Pointer wrap: FIFO read/write pointers wrap modulo DEPTH; the full condition is count==DEPTH.
- Start during FETCH or DRAIN: ignored.

Test Plan:
- Reset, then start, ROM holding words 0..9, out_ready=1 -> out_pc sequence 0..9 on consecutive cycles, first valid 2 cycles after start; done=1 one cycle after pc 9 is popped; exactly 10 pops.
- out_ready=0 for 5 cycles after the first valid -> count=2, imem_addr holds at 2, head stays pc 0; releasing out_ready resumes delivery as 0,1,2,... with no loss or duplication.
- redir_valid with redir_pc=7 while head=pc 3 and out_ready=1 -> pc 3 is not counted as accepted; next valid is pc 7 two cycles later, then 8, 9, then done.
- Redirect to 12 (out of range) during FETCH -> err=1, done=1, out_valid=0 next cycle; a subsequent start restarts at 0 with err still 1.
- Assert rst_n low mid-stream (count=2, pc=5) -> outputs clear immediately without waiting for a clock; after release, start fetches from 0.
- Redirect to 9 in the same cycle as a full-FIFO pop -> single entry pc 9 delivered, then DRAIN->DONE; start pulses during FETCH are ignored.
